part2_mac_result_fifo: RTL and testbench
========================================

// Module: part2_mac_result_fifo
// PURPOSE
//  Downstream of part2_mac. Captures each accumulator result (f, overflow) qualified by the MAC's valid_out
//  into a small show-ahead FIFO; drains via valid/ready. The MAC has no backpressure, so results arriving
//  while full are dropped and counted. Decouples MAC issue rate from the consumer (writeback/next layer).
// PARAMETERS
//  DATA_W   16                  width of stored result; must match MAC f width
//  DEPTH    4                   entries; power of two, >=2
//  DROP_W   8                   width of saturating drop counter
// PORTS
//  clk          in   1        rising-edge clock
//  reset_n      in   1        asynchronous, active-low reset
//  valid_in     in   1        from part2_mac valid_out; one result per asserted cycle
//  f_in         in   DATA_W   from part2_mac f (signed)
//  ovf_in       in   1        from part2_mac overflow
//  out_valid    out  1        head entry present
//  out_ready    in   1        consumer accepts head when out_valid & out_ready
//  out_data     out  DATA_W   head result (signed); holds last value when empty
//  out_ovf      out  1        head entry's overflow flag
//  count        out  $clog2(DEPTH+1)  occupancy
//  full         out  1        count==DEPTH
//  drop_pulse   out  1        registered, 1 cycle: a result was dropped last edge
//  drop_count   out  DROP_W   total drops, saturates at all-ones
//  ovf_sticky   out  1        [STICKY_OVF_EN only] see CONFIGURATION
//  clr_sticky   in   1        [STICKY_OVF_EN only]
// BEHAVIOUR
//  - Reset (reset_n low, async): pointers, count, out_valid, full, drop_pulse, drop_count, out_data, out_ovf,
//    ovf_sticky all 0. Storage contents are not reset. Asserting reset mid-stream discards all entries.
//  - push = valid_in & (~full | pop); pop = out_valid & out_ready. Both evaluated on the same edge.
//  - Latency: entry pushed at edge N is visible on out_valid/out_data after edge N (empty FIFO: 1 cycle).
//  - Show-ahead: out_data/out_ovf present head combinationally from storage at rd_ptr; held at last
//    popped value when empty (registered shadow) so outputs never show stale garbage.
//  - Full & push & pop same edge: accepted, count unchanged, no drop.
//  - Full & valid_in & ~pop: result dropped; drop_pulse=1 next cycle; drop_count += 1 unless saturated.
//  - Empty & out_ready: no pop, no underflow; count stays 0.
//  - Pointers are log2(DEPTH) bits, wrap naturally; count is separate register, updated +1/-1/0.
//  - Data stored verbatim (no sign change, no saturation); ovf_in stored alongside as bit DATA_W.
//  - No X propagation: when valid_in=0, f_in/ovf_in ignored.
// CONFIGURATION
//  STICKY_OVF_EN defined: ovf_sticky sets on any push with ovf_in=1, stays set until clr_sticky=1 edge;
//    simultaneous set and clear -> set wins. Ports ovf_sticky, clr_sticky exist.
//  STICKY_OVF_EN undefined: ports ovf_sticky and clr_sticky absent; no sticky register.
// STRUCTURE
//  Package part2_pkg: DATA_W constant (16), typedef mac_result_t {logic ovf; logic signed [DATA_W-1:0] f;}.
//  Top keeps push/pop/drop control and counters; sub-module part2_fifo_mem (DEPTH x mac_result_t
//  register array, sync write, async read) holds storage.
// TESTING
//  1 MAC sequence 4, 13, 49 with out_ready=1 -> out_valid one cycle after each push, data 4/13/49, count<=1.
//  2 out_ready=0, push 5 results (1,2,3,4,5), DEPTH=4 -> full after 4th; 5 dropped, drop_pulse one cycle,
//    drop_count=1; then drain -> 1,2,3,4 in order, empty, out_data holds 4.
//  3 Full, valid_in=1 and out_ready=1 same cycle with f_in=99 -> no drop, count stays 4, 99 emerges last.
//  4 Push f_in=-32768 with ovf_in=1 -> out_data=16'h8000, out_ovf=1; with STICKY_OVF_EN ovf_sticky=1
//    until clr_sticky; set+clear same cycle keeps 1.
//  5 Drop 300 results with DROP_W=8 -> drop_count saturates at 255.
//  6 Drop reset_n mid-stream with 3 entries, between edges -> out_valid, count, drop_count 0 immediately.

Source files
------------

// File: rtl/part2_pkg.sv
// Shared types and constants for the MAC result FIFO slice.
// A result is the MAC accumulator value plus its overflow flag, stored as one packed word
// with ovf in bit DATA_W.
package part2_pkg;

    localparam int unsigned DATA_W = 16;

    typedef struct packed {
        logic                     ovf;
        logic signed [DATA_W-1:0] f;
    } mac_result_t;

    // Saturating increment for an 8-bit counter; holds at all-ones.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hff) ? val : val + 8'd1;
    endfunction

endpackage

// File: rtl/part2_fifo_mem.sv
// Storage array for the MAC result FIFO: DEPTH entries of mac_result_t,
// synchronous write, asynchronous (combinational) read. Contents are not reset.
module part2_fifo_mem
    import part2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  mac_result_t              wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output mac_result_t              rdata_o
);

    mac_result_t mem_q [DEPTH];

    // Write port: one entry per accepted push.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: head entry is presented without a clock of latency (show-ahead).
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/part2_mac_result_fifo.sv
// Show-ahead result FIFO behind part2_mac. The MAC cannot be stalled, so a result arriving
// while the FIFO is full (and nothing pops that cycle) is dropped and counted.
// Optional feature: define STICKY_OVF_EN to add a sticky overflow flag (ovf_sticky) with
// its clear input (clr_sticky).
module part2_mac_result_fifo
    import part2_pkg::*;
#(
    parameter int unsigned DATA_W = part2_pkg::DATA_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         valid_in,
    input  logic signed [DATA_W-1:0]     f_in,
    input  logic                         ovf_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_W-1:0]     out_data,
    output logic                         out_ovf,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         drop_pulse,
    output logic [DROP_W-1:0]            drop_count
`ifdef STICKY_OVF_EN
    ,
    output logic                         ovf_sticky,
    input  logic                         clr_sticky
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    mac_result_t       shadow_q, shadow_d;
    logic              drop_pulse_q;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;

    mac_result_t       head;
    mac_result_t       wr_entry;
    logic              push, pop, drop;
    logic              not_empty, is_full;

    // Handshake decode: a pop frees a slot on the same edge, so full & push & pop is legal.
    always_comb begin
        not_empty = (count_q != '0);
        is_full   = (count_q == CntW'(DEPTH));
        pop       = not_empty & out_ready;
        push      = valid_in & (~is_full | pop);
        drop      = valid_in & is_full & ~pop;
        wr_entry  = '{ovf: ovf_in, f: f_in};
    end

    // Next-state for pointers, occupancy, shadow and drop counter.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        shadow_d     = shadow_q;
        drop_count_d = drop_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            // Remember the value leaving so the outputs hold it once empty.
            shadow_d = head;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + DROP_W'(1);
        end
    end

    // Control state register; storage itself lives in the memory and is not reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            shadow_q     <= '0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            shadow_q     <= shadow_d;
            drop_pulse_q <= drop;
            drop_count_q <= drop_count_d;
        end
    end

    part2_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // Output mux: live head when occupied, otherwise the last popped value.
    always_comb begin
        out_valid  = not_empty;
        full       = is_full;
        count      = count_q;
        drop_pulse = drop_pulse_q;
        drop_count = drop_count_q;
        out_data   = not_empty ? head.f   : shadow_q.f;
        out_ovf    = not_empty ? head.ovf : shadow_q.ovf;
    end

`ifdef STICKY_OVF_EN
    logic sticky_q, sticky_d;

    // Sticky overflow: set on any accepted push carrying ovf; set beats clear.
    always_comb begin
        sticky_d = sticky_q;
        if (push && ovf_in) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    // Sticky flag register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign ovf_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_part2_mac_result_fifo.sv
// Self-checking bench for part2_mac_result_fifo: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_part2_mac_result_fifo;

    typedef struct {
        logic [15:0] f;
        logic        ovf;
    } ent_t;

    logic        clk;
    logic        reset_n;
    logic        valid_in;
    logic [15:0] f_in;
    logic        ovf_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic [2:0]  count;
    logic        full;
    logic        drop_pulse;
    logic [7:0]  drop_count;
`ifdef STICKY_OVF_EN
    logic        ovf_sticky;
    logic        clr_sticky;
    logic        m_sticky;
`endif

    int          errors;
    int          checks;

    ent_t        mq[$];
    ent_t        m_shadow;
    int          m_drops;
    logic        m_pulse;

    part2_mac_result_fifo #(
        .DATA_W (16),
        .DEPTH  (4),
        .DROP_W (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid_in   (valid_in),
        .f_in       (f_in),
        .ovf_in     (ovf_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .count      (count),
        .full       (full),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count)
`ifdef STICKY_OVF_EN
        ,
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_shadow = '{f: 16'h0, ovf: 1'b0};
        m_drops  = 0;
        m_pulse  = 1'b0;
`ifdef STICKY_OVF_EN
        m_sticky = 1'b0;
`endif
    endtask

    task automatic check_all(input string tag);
        logic [15:0] ed;
        logic        eo;
        ed = (mq.size() > 0) ? mq[0].f   : m_shadow.f;
        eo = (mq.size() > 0) ? mq[0].ovf : m_shadow.ovf;
        chk({tag, ".out_valid"},  {31'd0, out_valid},  {31'd0, mq.size() > 0});
        chk({tag, ".count"},      {29'd0, count},      32'(mq.size()));
        chk({tag, ".full"},       {31'd0, full},       {31'd0, mq.size() == 4});
        chk({tag, ".out_data"},   {16'd0, out_data},   {16'd0, ed});
        chk({tag, ".out_ovf"},    {31'd0, out_ovf},    {31'd0, eo});
        chk({tag, ".drop_pulse"}, {31'd0, drop_pulse}, {31'd0, m_pulse});
        chk({tag, ".drop_count"}, {24'd0, drop_count}, 32'(m_drops));
`ifdef STICKY_OVF_EN
        chk({tag, ".ovf_sticky"}, {31'd0, ovf_sticky}, {31'd0, m_sticky});
`endif
    endtask

    // One clock: drive inputs, predict from queue rules, wait past the edge, compare.
    task automatic cycle(input string tag, input logic v, input logic [15:0] f, input logic o,
                         input logic r, input logic clr);
        bit do_pop, do_push, do_drop;
        ent_t e;
        valid_in  = v;
        f_in      = f;
        ovf_in    = o;
        out_ready = r;
`ifdef STICKY_OVF_EN
        clr_sticky = clr;
`endif
        do_pop  = (mq.size() > 0) && r;
        do_push = v && ((mq.size() < 4) || do_pop);
        do_drop = v && (mq.size() == 4) && !do_pop;
        @(posedge clk);
        #1;
        if (do_pop) m_shadow = mq.pop_front();
        if (do_push) begin
            e.f   = f;
            e.ovf = o;
            mq.push_back(e);
        end
        if (do_drop && m_drops < 255) m_drops++;
        m_pulse = do_drop;
`ifdef STICKY_OVF_EN
        if (do_push && o) m_sticky = 1'b1;
        else if (clr)     m_sticky = 1'b0;
`else
        if (clr) m_pulse = m_pulse;
`endif
        check_all(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 5; i++) cycle(tag, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset_n   = 1'b0;
        valid_in  = 1'b0;
        f_in      = 16'h0;
        ovf_in    = 1'b0;
        out_ready = 1'b0;
`ifdef STICKY_OVF_EN
        clr_sticky = 1'b0;
`endif
        model_reset();

        // Reset state.
        #12;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset");

        // 1: MAC sequence with consumer always ready.
        cycle("t1a", 1'b1, 16'd4, 1'b0, 1'b1, 1'b0);
        chk("t1_first", {16'd0, out_data}, 32'd4);
        cycle("t1b", 1'b1, 16'd13, 1'b0, 1'b1, 1'b0);
        cycle("t1c", 1'b1, 16'd49, 1'b0, 1'b1, 1'b0);
        cycle("t1d", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        chk("t1_hold", {16'd0, out_data}, 32'd49);

        // 2: overfill with consumer stalled, then drain.
        for (int i = 1; i <= 5; i++) cycle("t2_fill", 1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        chk("t2_pulse", {31'd0, drop_pulse}, 32'd1);
        chk("t2_drops", {24'd0, drop_count}, 32'd1);
        cycle("t2_idle", 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
        chk("t2_pulse_clr", {31'd0, drop_pulse}, 32'd0);
        drain("t2_drain");
        chk("t2_hold", {16'd0, out_data}, 32'd4);

        // 3: full with simultaneous push and pop.
        for (int i = 10; i < 14; i++) cycle("t3_fill", 1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        cycle("t3_both", 1'b1, 16'd99, 1'b0, 1'b1, 1'b0);
        chk("t3_count", {29'd0, count}, 32'd4);
        chk("t3_nodrop", {24'd0, drop_count}, 32'd1);
        drain("t3_drain");
        chk("t3_last", {16'd0, out_data}, 32'd99);

        // 4: most negative value with overflow flag.
        cycle("t4_push", 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0);
        chk("t4_data", {16'd0, out_data}, 32'h8000);
        chk("t4_ovf", {31'd0, out_ovf}, 32'd1);
        cycle("t4_setclr", 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
`ifdef STICKY_OVF_EN
        chk("t4_sticky_setwins", {31'd0, ovf_sticky}, 32'd1);
`endif
        cycle("t4_clr", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
`ifdef STICKY_OVF_EN
        chk("t4_sticky_clr", {31'd0, ovf_sticky}, 32'd0);
`endif
        drain("t4_drain");

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            cycle("rnd", 1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end
        drain("rnd_drain");

        // 5: drop counter saturation.
        for (int i = 0; i < 304; i++) cycle("t5", 1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        chk("t5_sat", {24'd0, drop_count}, 32'd255);

        // 6: asynchronous reset mid-stream with three entries.
        drain("t6_drain");
        for (int i = 0; i < 3; i++) cycle("t6_fill", 1'b1, 16'(i + 7), 1'b0, 1'b0, 1'b0);
        chk("t6_pre", {29'd0, count}, 32'd3);
        valid_in = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_count", {29'd0, count}, 32'd0);
        chk("t6_drops", {24'd0, drop_count}, 32'd0);
        check_all("t6_async");
        @(negedge clk);
        reset_n = 1'b1;
        cycle("t6_after", 1'b1, 16'd21, 1'b0, 1'b0, 1'b0);
        cycle("t6_pop", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
